imem_loader: RTL

Boot-time instruction-memory loader that sits directly upstream of the single-cycle CPU core. It accepts a framed byte stream, packs it into 32-bit big-endian instruction words, and writes them sequentially into the instruction memory's write port. The CPU is held in reset throughout. Once the frame's checksum verifies, it releases the CPU's reset so the core fetches from address 0.

---
 rtl/imem_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Accepts a framed byte stream (LEN_HI, LEN_LO, 4*N payload bytes with each
// word MSB first, CSUM). It packs the payload into 32-bit big-endian words
// and writes them to sequential word addresses. The CPU is held in reset
// until the XOR checksum over all preceding frame bytes matches CSUM.
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   rx_valid, rx_data  byte stream input
//   rx_ready           byte accepted when rx_valid & rx_ready at a rising edge
//   wr_en              one-cycle instruction-memory write strobe
//   wr_addr, wr_data   registered write word address and data (held when idle)
//   cpu_rst            CPU reset, released only once the load has verified
//   done, err          sticky success / failure flags
module imem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_q;
  logic [7:0]        xor_acc;

  logic              accept;
  logic [15:0]       len_rx;
  logic              too_long;
  logic              last_word;

  assign rx_ready = (state != S_DONE);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);
  assign cpu_rst  = (state != S_DONE);

  assign accept   = rx_valid & rx_ready;
  assign len_rx   = {len_hi, rx_data};
  assign too_long = 32'(len_rx) > 32'(MAX_WORDS);
  // Compared one bit wider than the length so N = 2^ADDR_W still matches
  // on its final word.
  assign last_word = ({1'b0, len} == (17'(word_idx) + 17'd1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (too_long)           state_nxt = S_ERR;
          else if (len_rx == '0)  state_nxt = S_CSUM;
          else                    state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && (byte_cnt == 2'd3) && last_word) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        if (accept) state_nxt = (rx_data == xor_acc) ? S_DONE : S_ERR;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_LEN_HI;
      len_hi   <= '0;
      len      <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
      xor_acc  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state <= state_nxt;
      wr_en <= 1'b0;
      if (accept) begin
        case (state)
          S_LEN_HI: begin
            len_hi  <= rx_data;
            xor_acc <= xor_acc ^ rx_data;
          end
          S_LEN_LO: begin
            len     <= len_rx;
            xor_acc <= xor_acc ^ rx_data;
          end
          S_DATA: begin
            xor_acc  <= xor_acc ^ rx_data;
            asm_q    <= {asm_q[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wr_en    <= 1'b1;
              wr_addr  <= word_idx;
              wr_data  <= {asm_q, rx_data};
              word_idx <= word_idx + ADDR_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
